// File: rtl/h_bridge_pkg.sv
// Shared types, step pattern table and step helpers
// for the H-bridge six-step sequencer.
package h_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_DRIVE,
        ST_FAULT
    } state_e;

    localparam int NUM_STEPS = 6;
    localparam logic [2:0] LAST_STEP = 3'd5;

    // Element 0 is the rightmost entry: {sw1,sw2,sw3}
    localparam logic [NUM_STEPS-1:0][2:0] STEP_PAT = {
        3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100
    };

    function automatic logic [2:0] step_pattern(
        input logic [2:0] idx
    );
        if (idx < 3'(NUM_STEPS)) begin
            return STEP_PAT[idx];
        end
        return 3'b000;
    endfunction

    function automatic logic [2:0] next_step(
        input logic [2:0] idx,
        input logic       rev
    );
        if (rev) begin
            return (idx == 3'd0) ? LAST_STEP : idx - 3'd1;
        end
        return (idx >= LAST_STEP) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/hb_watchdog.sv
// Heartbeat supervisor: synchronizes the host heartbeat,
// detects edges and pulses timeout when they stop while armed.
module hb_watchdog
    import h_bridge_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic watchdog_in,
    input  logic arm,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             pet;

    // Stages 0/1 synchronize; stage 2 is the previous value for edge detect
    always_comb begin
        sync_d    = {sync_q[1:0], watchdog_in};
        pet       = sync_q[2] ^ sync_q[1];
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (!arm || pet) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/h_bridge_sequencer.sv
// Six-step commutation controller with dead time, direction,
// start/stop handshake and watchdog fault latch.
module h_bridge_sequencer
    import h_bridge_pkg::*;
#(
    parameter int unsigned PERIOD_W    = 24,
    parameter int unsigned DEAD_W      = 8,
    parameter int unsigned WDOG_CYCLES = 2500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic [DEAD_W-1:0]   dead_cycles,
    input  logic                watchdog_in,
    input  logic                fault_clr,
    output logic                sw1,
    output logic                sw2,
    output logic                sw3,
    output logic                bridge_en,
    output logic                busy,
    output logic                fault,
    output logic [2:0]          step_idx,
    output logic                step_strobe
);

    localparam int unsigned CNT_W =
        (PERIOD_W > DEAD_W) ? PERIOD_W : DEAD_W;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       sw_q, sw_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] drive_len;
    logic [2:0]       nxt_idx;
    logic             timeout;

    hb_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .watchdog_in(watchdog_in),
        .arm        (busy_q),
        .timeout    (timeout)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sw_d      = sw_q;
        en_d      = en_q;
        busy_d    = busy_q;
        fault_d   = fault_q;
        strobe_d  = 1'b0;
        cnt_d     = cnt_q;
        nxt_idx   = next_step(idx_q, dir);
        drive_len = (step_period == '0) ? CNT_W'(1)
                                        : CNT_W'(step_period);
        case (state_q)
            ST_IDLE: begin
                if (start && !stop && !fault_q) begin
                    idx_d  = 3'd0;
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    if (dead_cycles == '0) begin
                        state_d  = ST_DRIVE;
                        sw_d     = step_pattern(3'd0);
                        strobe_d = 1'b1;
                        cnt_d    = drive_len;
                    end else begin
                        state_d = ST_DEAD;
                        sw_d    = 3'b000;
                        cnt_d   = CNT_W'(dead_cycles);
                    end
                end
            end
            ST_DEAD, ST_DRIVE: begin
                if (timeout) begin
                    state_d = ST_FAULT;
                    sw_d    = 3'b000;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else if (stop || !start) begin
                    state_d = ST_IDLE;
                    sw_d    = 3'b000;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (state_q == ST_DEAD) begin
                    state_d  = ST_DRIVE;
                    sw_d     = step_pattern(idx_q);
                    strobe_d = 1'b1;
                    cnt_d    = drive_len;
                end else begin
                    // Step expiry: direction is sampled here
                    idx_d = nxt_idx;
                    if (dead_cycles == '0) begin
                        sw_d     = step_pattern(nxt_idx);
                        strobe_d = 1'b1;
                        cnt_d    = drive_len;
                    end else begin
                        state_d = ST_DEAD;
                        sw_d    = 3'b000;
                        cnt_d   = CNT_W'(dead_cycles);
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr && !start) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sw_d    = 3'b000;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            sw_q     <= 3'b000;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sw_q     <= sw_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw1         = sw_q[2];
    assign sw2         = sw_q[1];
    assign sw3         = sw_q[0];
    assign bridge_en   = en_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign step_idx    = idx_q;
    assign step_strobe = strobe_q;

endmodule

// File: tb/tb_h_bridge_sequencer.sv
// Self-checking bench for h_bridge_sequencer: vector table
// through a scoreboard queue plus hand-written corner sequences.
module tb_h_bridge_sequencer;

    localparam int WDOG = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir = 1'b0;
    logic [23:0] step_period = '0;
    logic [7:0]  dead_cycles = '0;
    logic        watchdog_in = 1'b0;
    logic        fault_clr = 1'b0;
    logic        sw1, sw2, sw3, bridge_en, busy, fault, step_strobe;
    logic [2:0]  step_idx;

    h_bridge_sequencer #(
        .PERIOD_W   (24),
        .DEAD_W     (8),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .step_period(step_period),
        .dead_cycles(dead_cycles),
        .watchdog_in(watchdog_in),
        .fault_clr  (fault_clr),
        .sw1        (sw1),
        .sw2        (sw2),
        .sw3        (sw3),
        .bridge_en  (bridge_en),
        .busy       (busy),
        .fault      (fault),
        .step_idx   (step_idx),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        dir;
        logic [23:0] period;
        logic [7:0]  dead;
        logic [2:0]  sw;
        logic        en;
        logic        busy;
        logic        strobe;
        logic [2:0]  idx;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    logic [2:0] pat[6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    int         n_checks = 0;
    int         n_pass = 0;

    // {sw1,sw2,sw3,bridge_en,busy,step_strobe,fault,step_idx}
    function automatic logic [9:0] outs();
        return {sw1, sw2, sw3, bridge_en, busy, step_strobe, fault, step_idx};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic sp, input logic d,
                       input logic [23:0] p, input logic [7:0] dc,
                       input logic [2:0] sw, input logic en,
                       input logic bz, input logic stb,
                       input logic [2:0] idx);
        vec_t v;
        v.start = s; v.stop = sp; v.dir = d; v.period = p; v.dead = dc;
        v.sw = sw; v.en = en; v.busy = bz; v.strobe = stb; v.idx = idx;
        tbl.push_back(v);
    endtask

    task automatic add_step(input int s, input int p, input int dc,
                            input int drive_cyc, input logic [2:0] idx);
        for (int c = 0; c < dc; c++)
            add(1, 0, 0, 24'(p), 8'(dc), 3'b000, 1, 1, 0, idx);
        for (int c = 0; c < drive_cyc; c++)
            add(1, 0, 0, 24'(p), 8'(dc), pat[idx], 1, 1, c == 0, idx);
        if (s < 0) $display("unused");
    endtask

    initial begin
        logic [9:0] got, exp;
        int         cnt;
        int         seen;
        bit         hit;

        // Forward run, period 4, dead 2, seven steps incl. wrap
        for (int s = 0; s < 7; s++) add_step(s, 4, 2, 4, 3'(s % 6));
        add(0, 0, 0, 4, 2, 3'b000, 0, 0, 0, 3'd0);
        // Mid-step stop on cycle 2 of step 1, then restart from 0
        add_step(0, 4, 2, 4, 3'd0);
        add_step(1, 4, 2, 2, 3'd1);
        add(1, 1, 0, 4, 2, 3'b000, 0, 0, 0, 3'd1);
        add(1, 0, 0, 4, 2, 3'b000, 1, 1, 0, 3'd0);
        add(0, 0, 0, 4, 2, 3'b000, 0, 0, 0, 3'd0);
        // stop beats start in IDLE
        add(1, 1, 0, 4, 2, 3'b000, 0, 0, 0, 3'd0);
        add(0, 0, 0, 4, 2, 3'b000, 0, 0, 0, 3'd0);
        // Reverse, no dead time, period 1
        add(1, 0, 1, 1, 0, 3'b100, 1, 1, 1, 3'd0);
        add(1, 0, 1, 1, 0, 3'b101, 1, 1, 1, 3'd5);
        add(1, 0, 1, 1, 0, 3'b001, 1, 1, 1, 3'd4);
        add(1, 0, 1, 1, 0, 3'b011, 1, 1, 1, 3'd3);
        add(1, 0, 1, 1, 0, 3'b010, 1, 1, 1, 3'd2);
        add(0, 0, 1, 1, 0, 3'b000, 0, 0, 0, 3'd2);
        // Period 0 behaves as 1
        add(1, 0, 0, 0, 0, 3'b100, 1, 1, 1, 3'd0);
        add(1, 0, 0, 0, 0, 3'b110, 1, 1, 1, 3'd1);
        add(1, 0, 0, 0, 0, 3'b010, 1, 1, 1, 3'd2);
        add(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'd2);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("reset_state", 32'(outs()), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; stop = tbl[i].stop; dir = tbl[i].dir;
            step_period = tbl[i].period; dead_cycles = tbl[i].dead;
            sb.push_back({tbl[i].sw, tbl[i].en, tbl[i].busy,
                          tbl[i].strobe, 1'b0, tbl[i].idx});
            tick();
            got = outs();
            exp = sb.pop_front();
            chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
        end
        stop = 1'b0;

        // Watchdog timeout with static heartbeat
        start = 1'b1; dir = 1'b0; step_period = 4; dead_cycles = 2;
        tick();
        chk("wd_busy", 32'(busy), 32'h1);
        cnt = 0; hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            cnt++;
            if (fault) hit = 1;
        end
        chk("wd_fault_seen", 32'(hit), 32'h1);
        chk("wd_latency_ok", 32'(cnt >= WDOG && cnt <= WDOG + 4), 32'h1);
        chk("wd_outputs_off", 32'({sw1, sw2, sw3, bridge_en, busy}), 32'h0);
        fault_clr = 1'b1;
        tick();
        chk("wd_clr_ignored", 32'(fault), 32'h1);
        start = 1'b0;
        tick();
        chk("wd_clr_ok", 32'({fault, busy}), 32'h0);
        fault_clr = 1'b0;
        tick();

        // Heartbeat toggled every 50 cycles keeps fault clear
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 49) watchdog_in = ~watchdog_in;
            tick();
            if (fault) seen++;
        end
        chk("pet_no_fault", 32'(seen), 32'h0);
        chk("pet_still_busy", 32'(busy), 32'h1);
        start = 1'b0;
        tick();
        chk("pet_stop", 32'({bridge_en, busy}), 32'h0);

        // Async reset while driving
        start = 1'b1; step_period = 4; dead_cycles = 2;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            if ({sw1, sw2, sw3} != 3'b000) hit = 1;
        end
        chk("rst_reach_drive", 32'(hit), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 32'(outs()), 32'h0);
        start = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("rst_idle_after", 32'(outs()), 32'h0);
        start = 1'b1;
        tick();
        chk("rst_restart", 32'(outs()), 32'({3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0}));
        start = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/h_bridge_sequencer.md
Name: h_bridge_sequencer

Overview:
- Six-step commutation controller for the three-switch H-bridge driver. It generates sw1/sw2/sw3 switch commands and the bridge enable.
- Inserts programmable all-off dead time between steps, supports forward and reverse direction, and uses a start/stop handshake.
- Supervises a host watchdog heartbeat and latches a fault when it stops.
- Sits between host control logic and the h_bridge driver. Replaces the free-running test pattern generator.

Parameters:
- PERIOD_W, 24, width of step_period (drive cycles per step).
- DEAD_W, 8, width of dead_cycles.
- WDOG_CYCLES, 2500000, clk cycles allowed between heartbeat edges (50 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; 1 requests running.
- stop  in  1  pulse; immediate controlled stop.
- dir  in  1  0 = forward, 1 = reverse; sampled at each step boundary.
- step_period  in  PERIOD_W  drive cycles per step; 0 is treated as 1.
- dead_cycles  in  DEAD_W  all-off cycles before each step; 0 means no dead time.
- watchdog_in  in  1  asynchronous heartbeat; any edge pets the watchdog.
- fault_clr  in  1  pulse; clears the latched fault.
- sw1, sw2, sw3  out  1 each  switch commands to the h_bridge.
- bridge_en  out  1  enable to the h_bridge.
- busy  out  1  high in DEAD or DRIVE.
- fault  out  1  latched watchdog fault.
- step_idx  out  3  current step, 0..5.
- step_strobe  out  1  one-cycle pulse on entering DRIVE.

Behaviour:
- Reset values: sw1..sw3 = 0, bridge_en = 0, busy = 0, fault = 0, step_idx = 0, step_strobe = 0. State = IDLE. All counters = 0. The watchdog counter is held at 0 while in IDLE.
- Step patterns {sw1,sw2,sw3}:
  - 0 = 100, 1 = 110, 2 = 010, 3 = 011, 4 = 001, 5 = 101.
  - Forward: idx+1, wrapping 5 to 0.
  - Reverse: idx-1, wrapping 0 to 5.
- All outputs are registered. A pattern is never driven outside DRIVE; sw is all 0 in IDLE, DEAD and FAULT.
- States: IDLE, DEAD, DRIVE, FAULT.
- IDLE:
  - If start=1, stop=0 and fault=0: next state is DEAD, step_idx = 0, bridge_en = 1 and busy = 1 on the next cycle.
- DEAD:
  - sw = 000.
  - Counts dead_cycles cycles, then enters DRIVE.
  - If dead_cycles = 0, DEAD lasts 0 cycles and control goes straight to DRIVE.
- DRIVE:
  - sw = pattern[step_idx]. step_strobe is high on the first DRIVE cycle.
  - Holds for max(step_period, 1) cycles, latched on entry.
  - At expiry: advance step_idx per dir, sampled that cycle, then enter DEAD.
  - Exception: with dead_cycles = 0, re-enter DRIVE directly with the new pattern. No gap cycle; step_strobe pulses again.
- Configuration changes take effect only at step or dead boundaries, never mid-interval.
- Stop (stop pulse or start = 0) in DEAD or DRIVE:
  - Next cycle: sw = 000, bridge_en = 0, busy = 0, state = IDLE.
  - step_idx is held and reset to 0 on the next start.
  - stop has priority over start when both are asserted in the same cycle.
- Watchdog:
  - watchdog_in passes through a 2-flop synchronizer plus an edge detector.
  - Counter clears on every detected edge and increments each cycle while busy.
  - Reaching WDOG_CYCLES → FAULT next cycle: sw = 000, bridge_en = 0, busy = 0, fault = 1.
  - Fault takes precedence over stop and step expiry in the same cycle.
- FAULT:
  - Exit only when fault_clr = 1 and start = 0. Next cycle: fault = 0, state = IDLE.
  - fault_clr with start = 1 is ignored.
- Reset mid-operation: asynchronous; every output returns to its reset value immediately.

Decomposition:
- Shared package h_bridge_pkg holds:
  - state enum (IDLE, DEAD, DRIVE, FAULT);
  - step pattern table constant (6 × 3 bits);
  - NUM_STEPS = 6.
- Sub-module hb_watchdog: synchronizer, edge detector, timeout counter. Inputs: clk, rst_n, watchdog_in, arm. Output: timeout (one-cycle pulse).

Test Plan:
- Forward run: step_period = 4, dead_cycles = 2, dir = 0, start = 1. Expect:
  - sw sequence 100, 110, 010, 011, 001, 101, 100 (wrap);
  - each pattern held 4 cycles with 2 cycles of 000 between;
  - step_strobe once per step.
- Reverse with zero dead time: dir = 1, dead_cycles = 0, step_period = 1. Expect:
  - step_idx 0, 5, 4, 3 on consecutive cycles;
  - sw never 000 while busy.
- Mid-step stop: stop pulse on cycle 2 of step 1. Expect sw = 000, bridge_en = 0, busy = 0 on the next cycle, and state IDLE.
- Watchdog timeout with WDOG_CYCLES = 100 and watchdog_in static. Expect:
  - fault = 1 and outputs off 100 cycles (+ sync latency) after busy;
  - fault_clr while start = 1 is ignored;
  - fault_clr with start = 0 clears the fault.
- Watchdog pet: toggle watchdog_in every 50 cycles over 1000 cycles. Expect fault to stay 0.
- Async reset: assert rst_n = 0 during DRIVE. Expect all outputs 0 without a clock edge, and IDLE after release.
